conv_encoder_param: RTL and testbench

- Parametrised rate-1/N_OUT convolutional encoder, next generation of the LTE turbo/conv datapath encoder; sits between the block-input byte FIFO and the subblock interleaver.
- Runtime block length, runtime mode select (tail-biting or zero-terminated), generator polynomials set by parameter.
- Ready/valid handshakes on input and output with full backpressure.
- Packs each output stream LSB-first into OUT_W-bit words.

---
 rtl/conv_pkg.sv | 31 +++
 rtl/conv_word_packer.sv | 88 ++++++++
 rtl/conv_encoder_param.sv | 197 +++++++++++++++++++
 tb/tb_conv_encoder_param.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared definitions for the convolutional encoder: LTE generators, FSM states
// and the per-stream parity helper.
package conv_pkg;

    localparam logic [6:0] LTE_G0 = 7'o133;
    localparam logic [6:0] LTE_G1 = 7'o171;
    localparam logic [6:0] LTE_G2 = 7'o165;

    // Widest constraint length the parity helper supports.
    localparam int MAX_K = 16;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ENCODE,
        FLUSH,
        DRAIN
    } fsm_state_e;

    // window[j] is the bit from j steps ago; generator bit k-1 taps window[0],
    // so the generator is bit-reversed into tap order before the AND-reduce.
    function automatic logic gen_parity(input logic [MAX_K-1:0] window,
                                        input logic [MAX_K-1:0] gen,
                                        input int k);
        logic [MAX_K-1:0] taps;
        taps = {<<{gen}};
        taps = taps >> (MAX_K - k);
        return ^(window & taps);
    endfunction

endpackage

// File: rtl/conv_word_packer.sv
// Packs N_OUT parallel coded bit streams LSB-first into OUT_W-bit words and
// holds one completed word behind a ready/valid handshake.
module conv_word_packer
    import conv_pkg::*;
#(
    parameter int N_OUT = 3,
    parameter int OUT_W = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     bit_req,
    input  logic [N_OUT-1:0]         bit_data,
    input  logic                     bit_last,
    output logic                     stall,
    output logic                     out_valid,
    output logic [N_OUT*OUT_W-1:0]   out_data,
    output logic                     out_last,
    input  logic                     out_ready
);

    localparam int CNT_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;

    logic [N_OUT*OUT_W-1:0] acc_q, acc_d, acc_new;
    logic [N_OUT*OUT_W-1:0] data_q, data_d;
    logic [CNT_W-1:0]       wcnt_q, wcnt_d;
    logic                   valid_q, valid_d;
    logic                   last_q, last_d;
    logic [OUT_W-1:0]       bit_mask;
    logic                   word_done;
    logic                   load_ok;
    logic                   advance;

    assign bit_mask = OUT_W'(1) << wcnt_q;

    // Accumulator bits at and above wcnt are always zero, so OR-in is enough.
    generate
        for (genvar gi = 0; gi < N_OUT; gi++) begin : g_stream
            assign acc_new[gi*OUT_W +: OUT_W] =
                acc_q[gi*OUT_W +: OUT_W] | (bit_data[gi] ? bit_mask : '0);
        end
    endgenerate

    assign word_done = bit_last || (wcnt_q == CNT_W'(OUT_W - 1));
    assign load_ok   = !valid_q || out_ready;
    assign stall     = bit_req && word_done && !load_ok;
    assign advance   = bit_req && !stall;

    always_comb begin
        acc_d   = acc_q;
        wcnt_d  = wcnt_q;
        valid_d = valid_q && !out_ready;
        data_d  = data_q;
        last_d  = last_q && valid_d;
        if (advance) begin
            if (word_done) begin
                acc_d   = '0;
                wcnt_d  = '0;
                valid_d = 1'b1;
                data_d  = acc_new;
                last_d  = bit_last;
            end else begin
                acc_d  = acc_new;
                wcnt_d = wcnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q   <= '0;
            wcnt_q  <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            wcnt_q  <= wcnt_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            last_q  <= last_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_last  = last_q;

endmodule

// File: rtl/conv_encoder_param.sv
// Rate-1/N_OUT convolutional encoder with runtime block length and
// tail-biting / zero-terminated mode; byte input, packed word output.
module conv_encoder_param
    import conv_pkg::*;
#(
    parameter int                 K     = 7,
    parameter int                 N_OUT = 3,
    parameter logic [N_OUT*K-1:0] GEN   = {LTE_G2, LTE_G1, LTE_G0},
    parameter int                 OUT_W = 8,
    parameter int                 LEN_W = 13
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [LEN_W-1:0]       blk_len,
    input  logic                   tail_mode,
    input  logic [K-2:0]           init_state,
    input  logic                   in_valid,
    input  logic [7:0]             in_data,
    output logic                   in_ready,
    output logic                   out_valid,
    output logic [N_OUT*OUT_W-1:0] out_data,
    output logic                   out_last,
    input  logic                   out_ready,
    output logic                   busy,
    output logic                   done
);

    localparam int FCNT_W = (K > 2) ? $clog2(K - 1) : 1;

    fsm_state_e        state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic              mode_q, mode_d;
    logic [K-2:0]      enc_state_q, enc_state_d;
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;
    logic [7:0]        buf_q, buf_d;
    logic              buf_valid_q, buf_valid_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              cur_bit;
    logic [K-1:0]      window;
    logic [N_OUT-1:0]  parity;
    logic              final_enc;
    logic              fcnt_last;
    logic              bit_req;
    logic              bit_last;
    logic              stall;
    logic              advance;
    logic              take;
    logic              last_accept;

    assign cur_bit = (state_q == ENCODE) ? buf_q[bit_idx_q] : 1'b0;
    assign window  = {enc_state_q, cur_bit};

    generate
        for (genvar gi = 0; gi < N_OUT; gi++) begin : g_parity
            assign parity[gi] = gen_parity(MAX_K'(window), MAX_K'(GEN[gi*K +: K]), K);
        end
    endgenerate

    assign final_enc   = (cnt_q == len_q - LEN_W'(1));
    assign fcnt_last   = (fcnt_q == FCNT_W'(K - 2));
    assign bit_req     = ((state_q == ENCODE) && buf_valid_q) || (state_q == FLUSH);
    assign bit_last    = ((state_q == ENCODE) && final_enc && mode_q) ||
                         ((state_q == FLUSH) && fcnt_last);
    assign advance     = bit_req && !stall;
    // A refill is only allowed when the buffer is empty or its last bit leaves
    // this cycle; the final byte's leftover bits are never followed by a fetch.
    assign in_ready    = (state_q == ENCODE) &&
                         (!buf_valid_q || (advance && (bit_idx_q == 3'd7) && !final_enc));
    assign take        = in_ready && in_valid;
    assign last_accept = out_valid && out_ready && out_last;

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        mode_d      = mode_q;
        enc_state_d = enc_state_q;
        fcnt_d      = fcnt_q;
        buf_d       = buf_q;
        buf_valid_d = buf_valid_q;
        bit_idx_d   = bit_idx_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = LOAD;
                    len_d       = blk_len;
                    mode_d      = tail_mode;
                    enc_state_d = tail_mode ? init_state : '0;
                    busy_d      = 1'b1;
                end
            end
            LOAD: begin
                cnt_d       = '0;
                fcnt_d      = '0;
                buf_valid_d = 1'b0;
                bit_idx_d   = '0;
                if (len_q == '0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    state_d = ENCODE;
                end
            end
            ENCODE: begin
                if (advance) begin
                    enc_state_d = window[K-2:0];
                    cnt_d       = cnt_q + LEN_W'(1);
                    bit_idx_d   = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7 || final_enc) begin
                        buf_valid_d = 1'b0;
                    end
                    if (final_enc) begin
                        state_d = mode_q ? DRAIN : FLUSH;
                    end
                end
                if (take) begin
                    buf_d       = in_data;
                    buf_valid_d = 1'b1;
                    bit_idx_d   = '0;
                end
            end
            FLUSH: begin
                if (advance) begin
                    enc_state_d = window[K-2:0];
                    fcnt_d      = fcnt_q + FCNT_W'(1);
                    if (fcnt_last) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (last_accept) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            len_q       <= '0;
            cnt_q       <= '0;
            mode_q      <= 1'b0;
            enc_state_q <= '0;
            fcnt_q      <= '0;
            buf_q       <= '0;
            buf_valid_q <= 1'b0;
            bit_idx_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            mode_q      <= mode_d;
            enc_state_q <= enc_state_d;
            fcnt_q      <= fcnt_d;
            buf_q       <= buf_d;
            buf_valid_q <= buf_valid_d;
            bit_idx_q   <= bit_idx_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    conv_word_packer #(
        .N_OUT (N_OUT),
        .OUT_W (OUT_W)
    ) u_packer (
        .clk       (clk),
        .reset     (reset),
        .bit_req   (bit_req),
        .bit_data  (parity),
        .bit_last  (bit_last),
        .stall     (stall),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ready (out_ready)
    );

    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_conv_encoder_param.sv
// Directed bench for conv_encoder_param: circular/zero-extended reference
// model feeds a scoreboard of expected words checked on each handshake.
module tb_conv_encoder_param;

    localparam int K     = 7;
    localparam int N_OUT = 3;
    localparam int OUT_W = 8;
    localparam int LEN_W = 13;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   start;
    logic [LEN_W-1:0]       blk_len;
    logic                   tail_mode;
    logic [K-2:0]           init_state;
    logic                   in_valid;
    logic [7:0]             in_data;
    logic                   in_ready;
    logic                   out_valid;
    logic [N_OUT*OUT_W-1:0] out_data;
    logic                   out_last;
    logic                   out_ready;
    logic                   busy;
    logic                   done;

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [24:0] exp_q[$];
    logic [23:0] got_q[$];
    logic [23:0] ref_words[$];
    logic [7:0]  blk_bytes [0:15];
    logic [6:0]  gens [0:2];

    always #5 clk = ~clk;

    conv_encoder_param dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .blk_len    (blk_len),
        .tail_mode  (tail_mode),
        .init_state (init_state),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_last   (out_last),
        .out_ready  (out_ready),
        .busy       (busy),
        .done       (done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic ubit(input int n);
        logic [7:0] b;
        b = blk_bytes[n / 8];
        return b[n % 8];
    endfunction

    function automatic logic [K-2:0] tail_init(input int len);
        logic [K-2:0] r;
        for (int j = 0; j < K - 1; j++) r[j] = ubit(len - 1 - j);
        return r;
    endfunction

    // Direct convolution: earlier-than-start inputs wrap around in tail-biting
    // mode and are zero otherwise; inputs past the block end are zero (flush).
    function automatic int build_expected(input int len, input bit mode);
        int          nbits;
        int          nw;
        logic [23:0] w;
        logic [6:0]  g;
        logic        p;
        logic        v;
        int          n;
        nbits = (len == 0) ? 0 : (mode ? len : len + K - 1);
        nw = 0;
        w = '0;
        for (int k = 0; k < nbits; k++) begin
            for (int i = 0; i < N_OUT; i++) begin
                g = gens[i];
                p = 1'b0;
                for (int j = 0; j < K; j++) begin
                    n = k - j;
                    if (n < 0)         v = mode ? ubit(n + len) : 1'b0;
                    else if (n >= len) v = 1'b0;
                    else               v = ubit(n);
                    p = p ^ (v & g[K-1-j]);
                end
                w[i*OUT_W + (k % OUT_W)] = p;
            end
            if ((k % OUT_W) == OUT_W - 1 || k == nbits - 1) begin
                exp_q.push_back({(k == nbits - 1), w});
                nw++;
                w = '0;
            end
        end
        return nw;
    endfunction

    task automatic run_block(input int len, input bit mode, input logic [K-2:0] init,
                             input int stall_at, input int stall_len,
                             output int n_bytes, output int n_words,
                             output int done_cyc, output int first_rdy);
        int          byte_idx;
        int          n_exp;
        bit          in_fire;
        bit          prev_hold;
        bit          seen;
        logic [23:0] prev_data;
        logic [24:0] e;
        byte_idx  = 0;
        n_bytes   = 0;
        n_words   = 0;
        done_cyc  = -1;
        first_rdy = -1;
        prev_hold = 1'b0;
        prev_data = '0;
        seen      = 1'b0;
        got_q.delete();
        exp_q.delete();
        n_exp = build_expected(len, mode);
        @(posedge clk); #1;
        start      = 1'b1;
        blk_len    = LEN_W'(len);
        tail_mode  = mode;
        init_state = init;
        in_valid   = 1'b1;
        in_data    = blk_bytes[0];
        out_ready  = !(stall_len > 0 && stall_at == 0);
        for (int c = 0; c < 3000 && !seen; c++) begin
            @(negedge clk);
            in_fire = in_valid && in_ready;
            if (in_ready && first_rdy < 0) first_rdy = c;
            if (c == 1) check("busy_after_start", busy, 1);
            if (out_valid && out_ready) begin
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("sb_data", out_data, e[23:0]);
                    check("sb_last", out_last, e[24]);
                end
                got_q.push_back(out_data);
                n_words++;
            end
            if (out_valid && !out_ready) begin
                if (prev_hold) check("hold_stable", out_data, prev_data);
                prev_hold = 1'b1;
                prev_data = out_data;
            end else begin
                prev_hold = 1'b0;
            end
            if (stall_len > 0 && c == stall_at + stall_len - 1) begin
                check("stall_in_ready", in_ready, 0);
                check("stall_out_valid", out_valid, 1);
            end
            if (done) begin
                done_cyc = c;
                seen = 1'b1;
                check("busy_at_done", busy, 0);
            end
            @(posedge clk); #1;
            start = 1'b0;
            if (in_fire) begin
                n_bytes++;
                if (byte_idx < 15) byte_idx++;
            end
            in_data   = blk_bytes[byte_idx];
            out_ready = !(stall_len > 0 && c + 1 >= stall_at && c + 1 < stall_at + stall_len);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("done_seen", seen, 1);
        check("word_count", n_words, n_exp);
        check("sb_drained", exp_q.size(), 0);
        $display("block len=%0d mode=%0d bytes=%0d words=%0d done_cycle=%0d", len, mode, n_bytes, n_words, done_cyc);
    endtask

    initial begin
        int nb, nw, dc, fr;
        logic [K-2:0] ti;
        gens[0] = 7'o133;
        gens[1] = 7'o171;
        gens[2] = 7'o165;
        for (int i = 0; i < 16; i++) blk_bytes[i] = 8'($urandom);
        reset = 1'b1; start = 1'b0; blk_len = '0; tail_mode = 1'b0; init_state = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_out_data", out_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);

        // Impulse, zero-terminated
        blk_bytes[0] = 8'h01;
        run_block(1, 1'b0, '0, 0, 0, nb, nw, dc, fr);
        if (got_q.size() > 0) check("impulse_word", got_q[0], 24'h574F6D);
        check("impulse_bytes", nb, 1);
        check("impulse_first_ready", fr, 2);
        check("impulse_done_cycle", dc, 11);

        // All-zero tail-biting block
        blk_bytes[0] = 8'h00;
        run_block(8, 1'b1, '0, 0, 0, nb, nw, dc, fr);
        if (got_q.size() > 0) check("zero_word", got_q[0], 24'h000000);
        check("zero_bytes", nb, 1);

        // Tail-biting, 40 random bits
        for (int i = 0; i < 16; i++) blk_bytes[i] = 8'($urandom);
        ti = tail_init(40);
        run_block(40, 1'b1, ti, 0, 0, nb, nw, dc, fr);
        check("tb40_bytes", nb, 5);
        check("tb40_final_state", dut.enc_state_q, ti);
        ref_words = got_q;

        // Backpressure: same block with a 20-cycle output stall
        run_block(40, 1'b1, ti, 5, 20, nb, nw, dc, fr);
        check("bp_bytes", nb, 5);
        for (int i = 0; i < 5 && i < got_q.size() && i < ref_words.size(); i++)
            check("bp_same_stream", got_q[i], ref_words[i]);

        // Partial final byte, zero-terminated; init_state must be ignored
        run_block(13, 1'b0, 6'h2A, 0, 0, nb, nw, dc, fr);
        check("part_bytes", nb, 2);
        if (got_q.size() > 2) check("part_upper_zero", got_q[2] & 24'hF8F8F8, 0);

        // Zero-length block
        run_block(0, 1'b0, '0, 0, 0, nb, nw, dc, fr);
        check("len0_done_cycle", dc, 2);
        check("len0_bytes", nb, 0);

        // Reset in the middle of ENCODE
        @(posedge clk); #1;
        start = 1'b1; blk_len = 13'd40; tail_mode = 1'b0; init_state = '0;
        in_valid = 1'b1; in_data = blk_bytes[0];
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("abort_busy", busy, 1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort_in_ready", in_ready, 0);
        check("abort_out_valid", out_valid, 0);
        check("abort_out_data", out_data, 0);
        check("abort_out_last", out_last, 0);
        check("abort_busy_clr", busy, 0);
        check("abort_done", done, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        in_valid = 1'b0;
        blk_bytes[0] = 8'h01;
        run_block(1, 1'b0, '0, 0, 0, nb, nw, dc, fr);
        if (got_q.size() > 0) check("post_reset_word", got_q[0], 24'h574F6D);
        check("post_reset_done_cycle", dc, 11);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
